// File: rtl/note_event_fifo.sv
// rtl/note_event_fifo.sv - debounced note press/release events, timestamped and queued in a show-ahead FIFO
// Optional NOTE_EVT_DURATION_EN: release entries carry ticks held instead of the absolute timestamp.
module note_event_fifo #(
  parameter int DEPTH         = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int TICK_DIV      = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             note_id,
  input  logic [2:0]             octave,
  input  logic                   play_en,
  input  logic                   rd_en,
  input  logic                   clear,
  output logic [23:0]            evt_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [3:0]             cur_note
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [RW-1:0] RUN_MAX   = RW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;

  logic [3:0]    eff;
  logic [3:0]    raw_q, raw_d;
  logic [3:0]    cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;
  logic [3:0]    cur_q, cur_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_q, time_d;
  logic          tick;
  logic [1:0]    state_q, state_d;
  logic [3:0]    held_q, held_d;
  logic [2:0]    held_oct_q, held_oct_d;
  logic [3:0]    pend_q, pend_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [23:0]   mem_q [DEPTH];
  logic          wr_req;
  logic [23:0]   wr_entry;
  logic [15:0]   rel_time;
  logic          pop;
  logic          push_ok;
  logic          mem_we;

  always_comb begin
    eff = 4'd0;
    if (play_en && (note_id >= 4'd1) && (note_id <= 4'd12)) eff = note_id;
    raw_d = eff;
  end

  // A new candidate restarts the run; cur_note follows only after a saturated run.
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    cur_d  = cur_q;
    if (raw_q != cand_q) begin
      cand_d = raw_q;
      run_d  = '0;
    end else if (run_q == RUN_MAX) begin
      cur_d = cand_q;
    end else begin
      run_d = run_q + RW'(1);
    end
  end

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    time_d  = tick ? time_q + 16'd1 : time_q;
  end

`ifdef NOTE_EVT_DURATION_EN
  logic [15:0] held_ticks_q, held_ticks_d;

  always_comb begin
    held_ticks_d = held_ticks_q;
    if (wr_req && wr_entry[23]) begin
      held_ticks_d = 16'd0;
    end else if (tick && (held_ticks_q != 16'hFFFF)) begin
      held_ticks_d = held_ticks_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) held_ticks_q <= 16'd0;
    else       held_ticks_q <= held_ticks_d;
  end

  assign rel_time = held_ticks_q;
`else
  assign rel_time = time_q;
`endif

  // SWAP splits a direct note change into release-then-press, one write per cycle.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    held_oct_d = held_oct_q;
    pend_d     = pend_q;
    wr_req     = 1'b0;
    wr_entry   = 24'd0;
    case (state_q)
      ST_IDLE: begin
        if (cur_q != 4'd0) begin
          wr_req     = 1'b1;
          wr_entry   = {1'b1, octave, cur_q, time_q};
          held_d     = cur_q;
          held_oct_d = octave;
          state_d    = ST_HELD;
        end
      end
      ST_HELD: begin
        if (cur_q != held_q) begin
          wr_req   = 1'b1;
          wr_entry = {1'b0, held_oct_q, held_q, rel_time};
          pend_d   = cur_q;
          state_d  = (cur_q == 4'd0) ? ST_IDLE : ST_SWAP;
        end
      end
      ST_SWAP: begin
        wr_req     = 1'b1;
        wr_entry   = {1'b1, octave, pend_q, time_q};
        held_d     = pend_q;
        held_oct_d = octave;
        state_d    = ST_HELD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      wr_req  = 1'b0;
    end
  end

  always_comb begin
    pop      = rd_en && (count_q != '0);
    push_ok  = wr_req && ((count_q != DEPTH_C) || pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push_ok && !pop)      count_d = count_q + (AW + 1)'(1);
      else if (!push_ok && pop) count_d = count_q - (AW + 1)'(1);
      if (wr_req && !push_ok)   ovf_d = 1'b1;
    end
    mem_we = push_ok && !clear;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q      <= 4'd0;
      cand_q     <= 4'd0;
      run_q      <= '0;
      cur_q      <= 4'd0;
      presc_q    <= '0;
      time_q     <= 16'd0;
      state_q    <= ST_IDLE;
      held_q     <= 4'd0;
      held_oct_q <= 3'd0;
      pend_q     <= 4'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      raw_q      <= raw_d;
      cand_q     <= cand_d;
      run_q      <= run_d;
      cur_q      <= cur_d;
      presc_q    <= presc_d;
      time_q     <= time_d;
      state_q    <= state_d;
      held_q     <= held_d;
      held_oct_q <= held_oct_d;
      pend_q     <= pend_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign cur_note = cur_q;
  assign evt_data = empty ? 24'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_note_event_fifo.sv
// tb/tb_note_event_fifo.sv - randomized scoreboard bench for note_event_fifo
`timescale 1ns/1ps
module tb_note_event_fifo;

  localparam int DEPTH  = 16;
  localparam int STABLE = 4;
  localparam int TDIV   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  note_id;
  logic [2:0]  octave;
  logic        play_en;
  logic        rd_en;
  logic        clear;
  logic [23:0] evt_data;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic [3:0]  cur_note;

  always #5 clk = ~clk;

  note_event_fifo #(
    .DEPTH(DEPTH),
    .STABLE_CYCLES(STABLE),
    .TICK_DIV(TDIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .note_id(note_id),
    .octave(octave),
    .play_en(play_en),
    .rd_en(rd_en),
    .clear(clear),
    .evt_data(evt_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow),
    .cur_note(cur_note)
  );

  // Reference model: expected FIFO contents and flags after each edge.
  logic [23:0] exp_q[$];
  logic [3:0]  hist[$];
  logic        exp_ovf;
  logic [3:0]  exp_cur;
  int          m_state;
  logic [3:0]  m_held;
  logic [3:0]  m_pend;
  logic [2:0]  m_oct;
  int unsigned edges;
  int unsigned press_edges;

  int compared   = 0;
  int mismatched = 0;
  bit mon_en     = 1'b0;
  int max_fill   = 0;

  always @(posedge clk) begin : model_blk
    logic [3:0]  eff;
    logic [3:0]  cur_next;
    logic [15:0] ts;
    logic [15:0] rel;
    logic [23:0] ent;
    logic [23:0] dropped;
    bit          do_wr;
    bit          uniform;
    int unsigned dur;
    if (reset) begin
      edges   = 0;
      exp_ovf = 1'b0;
      exp_cur = 4'd0;
      m_state = 0;
      exp_q.delete();
      hist.delete();
      for (int i = 0; i <= STABLE; i++) hist.push_back(4'd0);
    end else begin
      eff = (play_en && note_id >= 4'd1 && note_id <= 4'd12) ? note_id : 4'd0;
      uniform = 1'b1;
      for (int i = 1; i <= STABLE; i++) if (hist[i] != hist[0]) uniform = 1'b0;
      cur_next = uniform ? hist[STABLE] : exp_cur;
      void'(hist.pop_front());
      hist.push_back(eff);

      ts = 16'((edges / TDIV) % 65536);
`ifdef NOTE_EVT_DURATION_EN
      dur = (edges / TDIV) - ((press_edges + 1) / TDIV);
      if (dur > 65535) dur = 65535;
      rel = 16'(dur);
`else
      dur = 0;
      rel = ts;
`endif
      do_wr = 1'b0;
      ent   = 24'd0;
      if (clear) begin
        m_state = 0;
      end else if (m_state == 0) begin
        if (exp_cur != 4'd0) begin
          do_wr = 1'b1; ent = {1'b1, octave, exp_cur, ts};
          m_held = exp_cur; m_oct = octave; press_edges = edges; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (exp_cur != m_held) begin
          do_wr = 1'b1; ent = {1'b0, m_oct, m_held, rel};
          m_pend = exp_cur; m_state = (exp_cur == 4'd0) ? 0 : 2;
        end
      end else begin
        do_wr = 1'b1; ent = {1'b1, octave, m_pend, ts};
        m_held = m_pend; m_oct = octave; press_edges = edges; m_state = 1;
      end

      if (clear) begin
        exp_q.delete();
        exp_ovf = 1'b0;
      end else begin
        if (rd_en && exp_q.size() != 0) dropped = exp_q.pop_front();
        if (do_wr) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(ent);
          else exp_ovf = 1'b1;
        end
      end
      if (exp_q.size() > max_fill) max_fill = exp_q.size();
      exp_cur = cur_next;
      edges++;
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", int'(count), exp_q.size());
      chk("empty", int'(empty), int'(exp_q.size() == 0));
      chk("full", int'(full), int'(exp_q.size() == DEPTH));
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("cur_note", int'(cur_note), int'(exp_cur));
      if (!empty) chk("evt_data", int'(evt_data), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
      else        chk("evt_data_empty", int'(evt_data), 0);
    end
  end

  task automatic step(input logic [3:0] n, input logic [2:0] o, input logic p,
                      input logic r, input logic c, input logic rs);
    @(negedge clk);
    #1;
    note_id = n; octave = o; play_en = p; rd_en = r; clear = c; reset = rs;
  endtask

  initial begin
    reset = 1'b1; note_id = 4'd0; octave = 3'd0; play_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // note 5, octave 3 held; glitch to 7 for two cycles; direct change to 9
    repeat (10) step(4'd5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2)  step(4'd7, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8)  step(4'd5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step(4'd9, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4)  step(4'd2, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step(4'd2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);

    // overfill with no reads, then pop exactly on the release write of a change
    for (int k = 0; k < 12; k++) repeat (8) step(4'(k % 12 + 1), 3'(k), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(4'd11, 3'd2, 1'b1, (i == STABLE + 2), 1'b0, 1'b0);
    step(4'd11, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (10) step(4'd11, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // randomized traffic with occasional clear and reset
    for (int cyc = 0; cyc < 4000; ) begin
      int len;
      logic [3:0] n;
      n   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        step(n, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0),
             1'($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0),
             ($urandom_range(0, 999) == 0));
        cyc++;
      end
    end

    repeat (40) step(4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    if (max_fill < DEPTH) $display("note: FIFO never reached depth in this run");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/note_event_fifo.md
Name: note_event_fifo

Overview:
- Downstream consumer of the piano front end's played-note id (0 = none, 1..12 = F..E) and octave select.
- Debounces the note id, converts level changes into timestamped press/release events, and buffers them in a FIFO.
- The pitch-training controller pops events from the FIFO for scoring.
- Sits between the piano keyboard path and the CPU/AXI-side register interface.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- STABLE_CYCLES, 4, consecutive identical samples required before a note id is accepted; >=1.
- TICK_DIV, 100000, clk cycles per timestamp tick (1 ms at 100 MHz); >=2.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- note_id  in  4  raw played-note id; 0 = no note; 13..15 treated as 0.
- octave  in  3  octave select, sampled with each accepted note.
- play_en  in  1  when 0, note_id is forced to 0 internally.
- rd_en  in  1  pop head entry; ignored when empty.
- clear  in  1  synchronous flush: FIFO emptied, overflow cleared, FSM to IDLE, timestamp kept.
- evt_data  out  24  head entry {type[23], octave[22:20], note[19:16], time[15:0]}; type 1 = press, 0 = release.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky; an event was dropped.
- cur_note  out  4  debounced note currently held (0 = none).

Behaviour:
- Reset: empty=1, full=0, count=0, overflow=0, cur_note=0, evt_data=0, timestamp=0, prescaler=0, FSM=IDLE.
- Input: eff = (play_en && note_id in 1..12) ? note_id : 0. Registered once into raw_q.
- Filter:
  - raw_q != cand: cand<=raw_q, run<=0.
  - Otherwise run saturates at STABLE_CYCLES-1. When run == STABLE_CYCLES-1, cur_note<=cand.
  - Timing: eff held constant from edge N makes cur_note update at edge N+STABLE_CYCLES+1.
- Timestamp:
  - Prescaler counts 0..TICK_DIV-1. On wrap, time increments 16-bit, 0xFFFF->0x0000.
  - Runs regardless of play_en or clear.
- FSM (one FIFO write per cycle maximum), acting on cur_note changes:
  - IDLE: cur_note 0->n: write press(n, oct) the next edge, go HELD, held<=n.
  - HELD: cur_note -> 0: write release(held), go IDLE.
  - HELD: cur_note -> m != held: write release(held), go SWAP.
  - SWAP: next edge write press(m), go HELD, held<=m. SWAP lasts exactly 1 cycle.
  - A change arriving while in SWAP is evaluated after returning to HELD.
  - Press captures octave at the write edge. Release reports the octave stored at press.
- FIFO: circular buffer, show-ahead.
  - evt_data = head entry whenever !empty; 0 when empty.
  - rd_en && !empty: pop; evt_data shows the next entry after the edge.
  - Write when full without a same-cycle pop: event dropped, overflow<=1, FSM still advances.
  - Write when full with a same-cycle pop: both occur, count unchanged, no overflow.
  - Write and pop when count==1: count stays 1, head becomes the new entry.
  - Read and write pointers wrap modulo DEPTH.
- clear has priority over the same-cycle write and pop. reset has priority over everything.
- Reset or clear mid-SWAP: the pending press is discarded.

Optional Feature:
- Macro NOTE_EVT_DURATION_EN.
- Defined: release time field = ticks elapsed since the matching press, saturating at 0xFFFF. A held-ticks counter clears at the press write and increments on each prescaler wrap. Press entries are unchanged.
- Undefined: release time field = absolute timestamp; no held-ticks counter is synthesised.

Test Plan:
- Reset, then note_id=5, octave=3, play_en=1 held 10 cycles:
  - cur_note=5 at edge STABLE_CYCLES+1.
  - empty falls one edge later.
  - evt_data = {1,3'd3,4'd5,time}.
- note_id glitch 5->7->5 with the 7 lasting 2 cycles (STABLE_CYCLES=4) -> no event generated, cur_note stays 5.
- Held 5 changes directly to 9 -> two consecutive entries, release(5) then press(9), SWAP lasting one cycle; count increases by 2.
- Generate 17 events with DEPTH=16 and no reads -> full=1, count=16, overflow=1, 16th entry retained. Then pop one with a simultaneous write -> count stays 16, overflow remains 1 until clear.
- play_en dropped while note 2 held -> release(2) after STABLE_CYCLES+2 edges. clear pulse -> empty=1, count=0, overflow=0, timestamp unaffected.
- TICK_DIV=4, time preloaded to 0xFFFE, hold a note across 3 ticks -> time wraps 0xFFFF->0x0000. With NOTE_EVT_DURATION_EN, press-to-release of 3 ticks gives release time=3.
